sdram_wbm: RTL and testbench

//  Wishbone master that drives the sdram Wishbone slave bridge from a simple local request port.

---
 rtl/sdram_wbm_pkg.sv | 17 +
 rtl/sdram_wbm_timeout.sv | 27 ++
 rtl/sdram_wbm.sv | 145 ++++++++++++++
 tb/tb_sdram_wbm.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wbm_pkg.sv
// rtl/sdram_wbm_pkg.sv - state encoding, beat counter width and default constants for sdram_wbm
package sdram_wbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_GAP  = 2'd2
  } wbm_state_t;

  localparam int DEFAULT_BURST_MAX   = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 255;

  function automatic int beat_cnt_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/sdram_wbm_timeout.sv
// rtl/sdram_wbm_timeout.sv - loadable down-counter, expire flags TIMEOUT_CYC cycles after load drops
module sdram_wbm_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= W'(TIMEOUT_CYC);
    end else if (load) begin
      cnt <= W'(TIMEOUT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0) && !load;

endmodule

// File: rtl/sdram_wbm.sv
// rtl/sdram_wbm.sv - Wishbone master splitting a local request into single-beat sdram transactions
// Optional ACT-phase timeout abort is built when SDRAM_WBM_TIMEOUT_EN is defined.
module sdram_wbm
  import sdram_wbm_pkg::*;
#(
  parameter int BURST_MAX = DEFAULT_BURST_MAX
`ifdef SDRAM_WBM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [15:0] wr_data,
  output logic        wr_data_pop,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] wbm_address,
  output logic [15:0] wbm_writedata,
  input  logic [15:0] wbm_readdata,
  output logic        wbm_strobe,
  output logic        wbm_cycle,
  output logic        wbm_write,
  input  logic        wbm_ack
);

  localparam int CW = beat_cnt_w(BURST_MAX);

  wbm_state_t    state;
  logic [CW-1:0] beats_left;

  function automatic logic [CW-1:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0) return CW'(1);
    if (int'(len) > BURST_MAX) return CW'(BURST_MAX);
    return CW'(len);
  endfunction

  assign req_ready = (state == ST_IDLE);

`ifdef SDRAM_WBM_TIMEOUT_EN
  logic tmo_expire;
  logic err_q;

  // Counter reloads whenever we are outside ACT, so every beat gets a full window.
  sdram_wbm_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (state != ST_ACT),
    .expire (tmo_expire)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      beats_left    <= '0;
      wbm_address   <= '0;
      wbm_writedata <= '0;
      wbm_strobe    <= 1'b0;
      wbm_cycle     <= 1'b0;
      wbm_write     <= 1'b0;
      wr_data_pop   <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;
`ifdef SDRAM_WBM_TIMEOUT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      wr_data_pop <= 1'b0;
`ifdef SDRAM_WBM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state       <= ST_ACT;
            wbm_address <= req_addr;
            wbm_write   <= req_write;
            beats_left  <= clamp_len(req_len);
            wbm_cycle   <= 1'b1;
            wbm_strobe  <= 1'b1;
            if (req_write) begin
              wbm_writedata <= wr_data;
              wr_data_pop   <= 1'b1;
            end
          end
        end
        ST_ACT: begin
          if (wbm_ack) begin
            wbm_strobe <= 1'b0;
            if (!wbm_write) begin
              rd_data  <= wbm_readdata;
              rd_valid <= 1'b1;
            end
            if (beats_left == CW'(1)) begin
              state     <= ST_IDLE;
              wbm_cycle <= 1'b0;
              done      <= 1'b1;
            end else begin
              state       <= ST_GAP;
              beats_left  <= beats_left - CW'(1);
              wbm_address <= wbm_address + 32'd1;
            end
          end
`ifdef SDRAM_WBM_TIMEOUT_EN
          else if (tmo_expire) begin
            state      <= ST_IDLE;
            wbm_strobe <= 1'b0;
            wbm_cycle  <= 1'b0;
            done       <= 1'b1;
            err_q      <= 1'b1;
          end
`endif
        end
        ST_GAP: begin
          // The slave starts an op on the rising edge of stb&cyc, hence the one-cycle drop.
          state      <= ST_ACT;
          wbm_strobe <= 1'b1;
          if (wbm_write) begin
            wbm_writedata <= wr_data;
            wr_data_pop   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wbm.sv
// tb/tb_sdram_wbm.sv - directed self-checking bench for sdram_wbm
module tb_sdram_wbm;

  localparam int TO_CYC = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [15:0] wr_data;
  logic        wr_data_pop;
  logic [15:0] rd_data;
  logic        rd_valid, done, err;
  logic [31:0] wbm_address;
  logic [15:0] wbm_writedata, wbm_readdata;
  logic        wbm_strobe, wbm_cycle, wbm_write, wbm_ack;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pop_cnt = 0;
  int rdv_cnt = 0;
  int fifo_head = 0;
  logic [15:0] fifo_mem [32];

  sdram_wbm dut (
    .clk           (clk),
    .reset         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .wr_data       (wr_data),
    .wr_data_pop   (wr_data_pop),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .done          (done),
    .err           (err),
    .wbm_address   (wbm_address),
    .wbm_writedata (wbm_writedata),
    .wbm_readdata  (wbm_readdata),
    .wbm_strobe    (wbm_strobe),
    .wbm_cycle     (wbm_cycle),
    .wbm_write     (wbm_write),
    .wbm_ack       (wbm_ack)
  );

  always #5 clk = ~clk;

  assign wr_data = fifo_mem[fifo_head[4:0]];

  always @(posedge clk) begin
    if (wr_data_pop) fifo_head <= fifo_head + 1;
    if (wr_data_pop) pop_cnt <= pop_cnt + 1;
    if (rd_valid) rdv_cnt <= rdv_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [3:0] len);
    check("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = we;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    check("act_latency", wbm_strobe, 1);
  endtask

  task automatic wb_beat(input logic [31:0] addr, input logic we, input logic [15:0] wdat,
                         input logic [15:0] rdat, input int dly, input bit last, input bit gap_ack);
    int n = 0;
    while (!wbm_strobe && n < 50) begin
      @(negedge clk);
      wbm_ack = 1'b0;
      n++;
    end
    check("stb_seen", wbm_strobe, 1);
    check("cyc_act", wbm_cycle, 1);
    check("addr", wbm_address, addr);
    check("we", wbm_write, we);
    check("pop", wr_data_pop, we);
    if (we) check("wdata", wbm_writedata, wdat);
    repeat (dly) @(negedge clk);
    check("stb_hold", wbm_strobe, 1);
    wbm_readdata = rdat;
    wbm_ack = 1'b1;
    @(negedge clk);
    wbm_ack = 1'b0;
    check("stb_drop", wbm_strobe, 0);
    check("rd_valid", rd_valid, !we);
    if (!we) check("rd_data", rd_data, rdat);
    check("done", done, last);
    check("cyc_after", wbm_cycle, !last);
    check("ready_after", req_ready, last);
    if (last) check("err_ok", err, 0);
    if (gap_ack) wbm_ack = 1'b1;
  endtask

  initial begin
    int d0, p0, r0, n;
    for (int i = 0; i < 32; i++) fifo_mem[i] = 16'hA1 + 16'(i);
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wbm_readdata = '0; wbm_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_stb", wbm_strobe, 0);
    check("rst_cyc", wbm_cycle, 0);
    check("rst_done", done, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_pop", wr_data_pop, 0);
    check("rst_addr", wbm_address, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // stray ack while idle
    wbm_ack = 1'b1;
    repeat (3) @(negedge clk);
    wbm_ack = 1'b0;
    check("idle_ack_cyc", wbm_cycle, 0);
    check("idle_ack_done", done_cnt, 0);
    @(negedge clk);

    // single read, ack three cycles after stb
    request(1'b0, 32'h100, 4'd1);
    wb_beat(32'h100, 1'b0, 16'h0, 16'hBEEF, 3, 1'b1, 1'b0);
    @(negedge clk);
    check("rd1_done_cnt", done_cnt, 1);
    check("rd1_rdv_cnt", rdv_cnt, 1);

    // write burst across the 32-bit address wrap, stray ack in the second GAP
    p0 = pop_cnt;
    request(1'b1, 32'hFFFF_FFFE, 4'd4);
    wb_beat(32'hFFFF_FFFE, 1'b1, 16'hA1, 16'h0, 0, 1'b0, 1'b0);
    wb_beat(32'hFFFF_FFFF, 1'b1, 16'hA2, 16'h0, 2, 1'b0, 1'b1);
    wb_beat(32'h0000_0000, 1'b1, 16'hA3, 16'h0, 1, 1'b0, 1'b0);
    wb_beat(32'h0000_0001, 1'b1, 16'hA4, 16'h0, 0, 1'b1, 1'b0);
    @(negedge clk);
    check("wr_pops", pop_cnt - p0, 4);
    check("wr_done_cnt", done_cnt, 2);
    check("wr_rdv_cnt", rdv_cnt, 1);

    // req_len=0 behaves as one beat
    request(1'b0, 32'h2000, 4'd0);
    wb_beat(32'h2000, 1'b0, 16'h0, 16'h1234, 1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("len0_no_beat2", wbm_strobe, 0);
    check("len0_done_cnt", done_cnt, 3);

    // req_len=12 clamps to 8 beats
    r0 = rdv_cnt;
    request(1'b0, 32'h40, 4'd12);
    for (int i = 0; i < 8; i++)
      wb_beat(32'h40 + 32'(i), 1'b0, 16'h0, 16'h5000 + 16'(i), i % 3, i == 7, 1'b0);
    repeat (3) @(negedge clk);
    check("len12_rdv", rdv_cnt - r0, 8);
    check("len12_done_cnt", done_cnt, 4);
    check("len12_idle", wbm_cycle, 0);

    // reset asserted in ACT of beat 2 of 4
    request(1'b1, 32'h300, 4'd4);
    wb_beat(32'h300, 1'b1, 16'hA5, 16'h0, 1, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_act2", wbm_strobe, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb", wbm_strobe, 0);
    check("mid_rst_cyc", wbm_cycle, 0);
    check("mid_rst_pop", wr_data_pop, 0);
    check("mid_rst_addr", wbm_address, 0);
    check("mid_rst_wdata", wbm_writedata, 0);
    check("mid_rst_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_still_idle", wbm_cycle, 0);

    // clean request after the reset
    request(1'b0, 32'h700, 4'd2);
    wb_beat(32'h700, 1'b0, 16'h0, 16'hC0DE, 0, 1'b0, 1'b0);
    wb_beat(32'h701, 1'b0, 16'h0, 16'hC0DF, 2, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_done", done_cnt - d0, 1);

`ifdef SDRAM_WBM_TIMEOUT_EN
    // no ack: abort after TO_CYC+1 cycles, remaining beat dropped
    request(1'b0, 32'h900, 4'd2);
    n = 0;
    while (wbm_strobe && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, TO_CYC + 1);
    check("to_done", done, 1);
    check("to_err", err, 1);
    check("to_cyc", wbm_cycle, 0);
    check("to_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check("to_dropped", wbm_strobe, 0);
    check("to_err_cnt", err_cnt, 1);

    // ack exactly in the expiry cycle completes the beat
    request(1'b0, 32'hA00, 4'd1);
    wb_beat(32'hA00, 1'b0, 16'h0, 16'h7777, TO_CYC, 1'b1, 1'b0);
    @(negedge clk);
    check("to_ack_err_cnt", err_cnt, 1);
`else
    repeat (2) @(negedge clk);
    check("err_never", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
